// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg: shared types and default widths for the IF/LS memory arbiter.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_MEM_LAT = 1;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick: combinational winner selection between the IF and LS ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LS has fixed priority.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  owner_t last_owner_i,
  output logic   grant_valid_o,
  output owner_t grant_owner_o
);

  assign grant_valid_o = if_req_i | ls_req_i;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_owner_o = OWN_LS;
    if (if_req_i && ls_req_i) begin
      // On a tie the port that did not win last time goes first.
      grant_owner_o = (last_owner_i == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (if_req_i) begin
      grant_owner_o = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
  assign grant_owner_o     = ls_req_i ? OWN_LS : OWN_IF;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter: shares one fixed-latency single-port memory between IF and LS.
// Optional MEM_ARB_RR_EN: round-robin arbitration on simultaneous requests.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t           state_q;
  owner_t           owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic   grant_valid;
  owner_t grant_owner;
  owner_t last_owner;
  logic   take;

  mem_arb_pick u_pick (
    .if_req_i      (if_req),
    .ls_req_i      (ls_req),
    .last_owner_i  (last_owner),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // Gated by reset so no grant can leak out while reset is asserted.
  assign take = reset & (state_q == IDLE) & grant_valid;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= OWN_LS;
    end else if (take) begin
      last_owner_q <= grant_owner;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_LS;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            we_q    <= (grant_owner == OWN_LS) & ls_we;
            cnt_q   <= LAT_M1;
            state_q <= (MEM_LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (take) begin
      mem_en = 1'b1;
      if (grant_owner == OWN_LS) begin
        ls_gnt    = 1'b1;
        mem_we    = ls_we;
        mem_be    = ls_be;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
      end else begin
        if_gnt   = 1'b1;
        mem_be   = '1;
        mem_addr = if_addr;
      end
    end
  end

  // Store acknowledges return zero data rather than whatever is on the bus.
  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
  assign if_rdata  = (if_rvalid && !we_q) ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;

endmodule

`default_nettype wire
